subtractor_32bit_seq: RTL

Multi-cycle 32-bit subtractor that computes `diff = a - b` one 8-bit slice per clock, rippling the borrow between slices through a registered flag. It is the inverse-direction companion to the team's hierarchical slice-based adders. It trades latency for a single reused 8-bit datapath, and sits behind valid/ready handshakes on both operand and result sides.

---
 rtl/sub_pkg.sv | 17 +
 rtl/subtractor_8bit.sv | 22 ++
 rtl/subtractor_32bit_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the sequential slice subtractor.
// Optional macro SUB_SATURATE_EN clamps underflowing results to zero.
package sub_pkg;

    localparam int SUB_WIDTH  = 32;
    localparam int SUB_SLICE  = 8;
    localparam int SUB_NSLICE = SUB_WIDTH / SUB_SLICE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    typedef logic [SUB_SLICE-1:0] sub_slice_t;

endpackage

// File: rtl/subtractor_8bit.sv
// Combinational slice subtractor with borrow in/out.
// Shared by every slice of the sequential subtractor.
module subtractor_8bit
    import sub_pkg::*;
#(
    parameter int W = SUB_SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] full;

    // Extra MSB of the W+1 bit result is the borrow out
    assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign diff = full[W-1:0];
    assign bout = full[W];

endmodule

// File: rtl/subtractor_32bit_seq.sv
// Multi-cycle subtractor: one slice per clock, borrow kept in a flag.
// Optional macro SUB_SATURATE_EN forces diff to zero on underflow.
module subtractor_32bit_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int SLICE = SUB_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bflag_q, bflag_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [SLICE-1:0] sa, sb, sd;
    logic             sbout;

    assign sa = a_q[SLICE*int'(idx_q) +: SLICE];
    assign sb = b_q[SLICE*int'(idx_q) +: SLICE];

    subtractor_8bit #(
        .W(SLICE)
    ) u_slice (
        .a   (sa),
        .b   (sb),
        .bin (bflag_q),
        .diff(sd),
        .bout(sbout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bflag_d = bflag_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    bflag_d = 1'b0;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                diff_d[SLICE*int'(idx_q) +: SLICE] = sd;
                bflag_d = sbout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bflag_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bflag_q <= bflag_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign borrow    = bflag_q;

`ifdef SUB_SATURATE_EN
    // Clamp only at the output; diff_q keeps the wrapped value
    assign diff = (out_valid && bflag_q) ? '0 : diff_q;
`else
    assign diff = diff_q;
`endif

endmodule
